armv4_multicycle: RTL

Multicycle ARMv4 core: one shared ALU, a flag register and a single unified instruction/data memory port with a ready handshake that tolerates wait states. It supersedes the single-cycle core at the top of the processor hierarchy. It adds variable-latency memory, stall, conditional execution from held NZCV flags, and a retired-instruction counter. It connects to one memory model or bus bridge; the top-level test harness instantiates it.

---
 rtl/armv4_pkg.sv | 65 ++++++
 rtl/armv4_mc_ctrl.sv | 110 +++++++++++
 rtl/armv4_multicycle.sv | 138 +++++++++++++
 3 files changed

// File: rtl/armv4_pkg.sv
// Shared types and constants for the multicycle ARMv4 core: FSM states,
// ALU operation codes, condition and opcode field values, decode record.
package armv4_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR,
    S_MEMRD, S_MEMWR, S_MEMWB, S_BRANCH
  } state_e;

  typedef enum logic [2:0] {ALU_AND, ALU_EOR, ALU_SUB, ALU_ADD, ALU_ORR} alu_op_e;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_CMP = 4'b1010;

  localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3;
  localparam logic [3:0] C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7;
  localparam logic [3:0] C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB;
  localparam logic [3:0] C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF;

  // Decoded view of the held instruction word
  typedef struct packed {
    logic    dp;    // data processing that writes Rd
    logic    cmp;   // CMP (flags only)
    logic    ld;
    logic    st;
    logic    br;
    logic    imm;   // operand 2 is a rotated immediate
    logic    s;
    logic    up;    // load/store offset added
    alu_op_e op;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;
  } dec_t;

  // Condition field check against held NZCV
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      C_EQ: return z;
      C_NE: return !z;
      C_CS: return cf;
      C_CC: return !cf;
      C_MI: return n;
      C_PL: return !n;
      C_VS: return v;
      C_VC: return !v;
      C_HI: return cf && !z;
      C_LS: return !cf || z;
      C_GE: return n == v;
      C_LT: return n != v;
      C_GT: return !z && (n == v);
      C_LE: return z || (n != v);
      C_AL: return 1'b1;
      C_NV: return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/armv4_mc_ctrl.sv
// Control for the multicycle core: instruction decode, condition check,
// state machine and memory handshake.
module armv4_mc_ctrl
  import armv4_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_ready,
  input  logic [31:0] i_ir,
  input  logic [3:0]  i_nzcv,
  output state_e      o_state,
  output dec_t        o_dec,
  output alu_op_e     o_alu_op,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_retire
);

  state_e r_state, w_next;
  logic   r_run;
  dec_t   w_dec;
  logic   w_pass, w_nop, w_req, w_done;

  assign o_state = r_state;
  assign o_dec   = w_dec;
  assign w_pass  = cond_pass(i_ir[31:28], i_nzcv);
  assign w_nop   = !(w_dec.dp || w_dec.cmp || w_dec.ld || w_dec.st || w_dec.br);
  // r_run keeps the bus quiet for the reset cycle itself
  assign w_req   = r_run && (r_state == S_FETCH || r_state == S_MEMRD || r_state == S_MEMWR);
  assign w_done  = w_req && i_mem_ready;

  // Classify the held instruction; anything unrecognised stays all-zero (NOP)
  always_comb begin
    w_dec     = '0;
    w_dec.imm = i_ir[25];
    w_dec.s   = i_ir[20];
    w_dec.up  = i_ir[23];
    w_dec.rn  = i_ir[19:16];
    w_dec.rd  = i_ir[15:12];
    w_dec.rm  = i_ir[3:0];
    w_dec.op  = ALU_ADD;
    if (i_ir[27:26] == 2'b00 && (i_ir[25] || i_ir[11:4] == 8'h00)) begin
      case (i_ir[24:21])
        OP_AND: begin w_dec.dp = 1'b1; w_dec.op = ALU_AND; end
        OP_EOR: begin w_dec.dp = 1'b1; w_dec.op = ALU_EOR; end
        OP_SUB: begin w_dec.dp = 1'b1; w_dec.op = ALU_SUB; end
        OP_ADD: begin w_dec.dp = 1'b1; w_dec.op = ALU_ADD; end
        OP_ORR: begin w_dec.dp = 1'b1; w_dec.op = ALU_ORR; end
        OP_CMP: if (i_ir[20]) begin w_dec.cmp = 1'b1; w_dec.op = ALU_SUB; end
        default: ;
      endcase
    end
    // word LDR/STR, immediate offset, pre-indexed, no writeback
    if (i_ir[27:25] == 3'b010 && i_ir[24] && !i_ir[22] && !i_ir[21]) begin
      w_dec.ld = i_ir[20];
      w_dec.st = !i_ir[20];
    end
    if (i_ir[27:24] == 4'b1010) w_dec.br = 1'b1;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_FETCH;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_done) w_next = S_DECODE;
      S_DECODE: begin
        if (!w_pass || w_nop)           w_next = S_FETCH;
        else if (w_dec.dp || w_dec.cmp) w_next = S_EXEC;
        else if (w_dec.ld || w_dec.st)  w_next = S_MEMADR;
        else                            w_next = S_BRANCH;
      end
      S_EXEC:   w_next = w_dec.cmp ? S_FETCH : S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_MEMADR: w_next = w_dec.ld ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (w_done) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (w_done) w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // Outputs: bus strobes, ALU select, retire on each instruction's last state
  always_comb begin
    o_mem_req = w_req;
    o_mem_we  = r_run && (r_state == S_MEMWR);
    o_alu_op  = ALU_ADD;
    o_retire  = 1'b0;
    case (r_state)
      S_DECODE: o_retire = !w_pass || w_nop;
      S_EXEC:   begin o_alu_op = w_dec.op; o_retire = w_dec.cmp; end
      S_MEMADR: o_alu_op = w_dec.up ? ALU_ADD : ALU_SUB;
      S_ALUWB, S_MEMWB, S_BRANCH: o_retire = 1'b1;
      S_MEMWR:  o_retire = w_done;
      default:  ;
    endcase
  end

endmodule

// File: rtl/armv4_multicycle.sv
// Multicycle ARMv4 core top: datapath around one shared ALU, NZCV register,
// register bank and a single unified memory port with ready handshake.
module armv4_multicycle
  import armv4_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  input  logic [31:0]      i_mem_rdata,
  input  logic             i_mem_ready,
  output logic             o_retire,
  output logic [CNT_W-1:0] o_instret
);

  state_e  w_state;
  dec_t    w_dec;
  alu_op_e w_alu_op;

  logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr, r_wd;
  logic [3:0]  r_nzcv;
  logic [31:0] r_rf [16];   // entry 15 is never used; R15 is r_pc
  logic [CNT_W-1:0] r_instret;

  logic [31:0] w_pc8, w_rn_v, w_rm_v, w_rd_v, w_imm8, w_immrot, w_boff;
  logic [4:0]  w_rot;
  logic [31:0] w_bx, w_res, w_rf_wd;
  logic [32:0] w_sum;
  logic        w_sub, w_c, w_v, w_fetch_done, w_wb, w_arith;

  armv4_mc_ctrl u_ctrl (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_mem_ready (i_mem_ready),
    .i_ir        (r_ir),
    .i_nzcv      (r_nzcv),
    .o_state     (w_state),
    .o_dec       (w_dec),
    .o_alu_op    (w_alu_op),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_retire    (o_retire)
  );

  assign w_fetch_done = o_mem_req && i_mem_ready && (w_state == S_FETCH);
  assign w_wb         = (w_state == S_ALUWB) || (w_state == S_MEMWB);
  assign w_rf_wd      = (w_state == S_MEMWB) ? r_mdr : r_alu;
  assign w_arith      = (w_dec.op == ALU_ADD) || (w_dec.op == ALU_SUB);
  assign o_mem_addr   = (w_state == S_MEMRD || w_state == S_MEMWR) ?
                        {r_alu[31:2], 2'b00} : {r_pc[31:2], 2'b00};
  assign o_mem_wdata  = r_wd;
  assign o_instret    = r_instret;

  // Operand fetch: R15 reads as instruction address + 8 (r_pc already +4)
  always_comb begin
    w_pc8    = r_pc + 32'd4;
    w_rn_v   = (w_dec.rn == 4'd15) ? w_pc8 : r_rf[w_dec.rn];
    w_rm_v   = (w_dec.rm == 4'd15) ? w_pc8 : r_rf[w_dec.rm];
    w_rd_v   = (w_dec.rd == 4'd15) ? w_pc8 : r_rf[w_dec.rd];
    w_rot    = {r_ir[11:8], 1'b0};
    w_imm8   = {24'h0, r_ir[7:0]};
    w_immrot = (w_imm8 >> w_rot) | (w_imm8 << (6'd32 - {1'b0, w_rot}));
    w_boff   = {{6{r_ir[23]}}, r_ir[23:0], 2'b00};
  end

  // Shared ALU; subtract is a + ~b + 1 so carry means "no borrow"
  always_comb begin
    w_sub = (w_alu_op == ALU_SUB);
    w_bx  = w_sub ? ~r_b : r_b;
    w_sum = {1'b0, r_a} + {1'b0, w_bx} + {32'h0, w_sub};
    w_res = w_sum[31:0];
    case (w_alu_op)
      ALU_AND: w_res = r_a & r_b;
      ALU_EOR: w_res = r_a ^ r_b;
      ALU_ORR: w_res = r_a | r_b;
      default: w_res = w_sum[31:0];
    endcase
    w_c = w_sum[32];
    w_v = (r_a[31] == w_bx[31]) && (w_sum[31] != r_a[31]);
  end

  // Datapath latches: IR on fetch, operands in DECODE, ALU/load results
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ir <= '0; r_a <= '0; r_b <= '0; r_alu <= '0; r_mdr <= '0; r_wd <= '0;
    end else begin
      if (w_fetch_done) r_ir <= i_mem_rdata;
      if (w_state == S_DECODE) begin
        r_a <= w_dec.br ? w_pc8 : w_rn_v;
        r_b <= w_dec.br ? w_boff :
               (w_dec.ld || w_dec.st) ? {20'h0, r_ir[11:0]} :
               w_dec.imm ? w_immrot : w_rm_v;
        if (w_dec.st) r_wd <= w_rd_v;
      end
      if (w_state == S_EXEC || w_state == S_MEMADR) r_alu <= w_res;
      if (w_state == S_MEMRD && o_mem_req && i_mem_ready) r_mdr <= i_mem_rdata;
    end
  end

  // Program counter: sequential step on fetch, redirects on R15 write or branch
  always_ff @(posedge i_clk) begin
    if (!i_rst)                            r_pc <= RESET_PC;
    else if (w_fetch_done)                 r_pc <= r_pc + 32'd4;
    else if (w_wb && w_dec.rd == 4'd15)    r_pc <= w_rf_wd;
    else if (w_state == S_BRANCH)          r_pc <= w_res;
  end

  // Register bank R0-R14 writeback
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
    end else if (w_wb && w_dec.rd != 4'd15) begin
      r_rf[w_dec.rd] <= w_rf_wd;
    end
  end

  // NZCV: N/Z from result; C/V only from the adder, held for logic ops
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_nzcv <= 4'h0;
    else if (w_state == S_EXEC && w_dec.s) begin
      r_nzcv[3] <= w_res[31];
      r_nzcv[2] <= (w_res == 32'h0);
      if (w_arith) r_nzcv[1:0] <= {w_c, w_v};
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge i_clk) begin
    if (!i_rst)        r_instret <= '0;
    else if (o_retire) r_instret <= r_instret + CNT_W'(1);
  end

endmodule
